branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter: ENTRIES, 64, number of direct-mapped entries (power of two, 16..256).
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_lookup_valid  in  1  fetch-stage lookup request.
REQ-005 SHALL have port: i_lookup_pc  in  ADDR_WIDTH  fetch PC.
REQ-006 SHALL have port: o_hit  out  1  valid entry with matching tag.
REQ-007 SHALL have port: o_pred_taken  out  1  predicted redirect.
REQ-008 SHALL have port: o_target  out  ADDR_WIDTH  predicted target.
REQ-009 SHALL have port: i_upd_valid  in  1  resolved-branch feedback from EX.
REQ-010 SHALL have port: i_upd_pc  in  ADDR_WIDTH  resolved branch PC.
REQ-011 SHALL have port: i_upd_target  in  ADDR_WIDTH  resolved taken target.
REQ-012 SHALL have port: i_upd_outcome  in  BranchOutcome  TAKEN / NOT_TAKEN.
REQ-013 SHALL have port: i_upd_is_jump  in  1  unconditional jump.
REQ-014 SHALL have ports: o_lookup_count, o_hit_count  out  32 each  statistics (see Configuration).

Function
REQ-015 SHALL derive index = pc[IDX+1:2], tag = pc[ADDR_WIDTH-1:IDX+2], IDX = log2(ENTRIES).
REQ-016 SHALL hold per entry: valid, tag, target, 2-bit saturating counter, jump flag.
REQ-017 SHALL compute lookup combinationally, zero latency: o_hit = i_lookup_valid & valid & tag match.
REQ-018 SHALL drive o_pred_taken = o_hit & (jump flag | counter[1]); o_target = entry target when o_hit, else 0.
REQ-019 SHALL, on update miss with TAKEN, allocate the entry: valid=1, tag, target, counter=2 (weakly taken), jump flag=i_upd_is_jump.
REQ-020 SHALL, on update miss with NOT_TAKEN, leave the table unchanged.
REQ-021 SHALL, on update hit, increment counter on TAKEN (saturate at 3), decrement on NOT_TAKEN (saturate at 0), and rewrite target when TAKEN.
REQ-022 SHALL force counter=3 and jump flag=1 on any update with i_upd_is_jump.
REQ-023 SHALL make update writes visible to lookups from the next cycle; a same-cycle lookup of the same index returns pre-update contents.
REQ-024 SHALL replace a conflicting tag at the same index only on a TAKEN update (aliasing eviction).

Reset
REQ-025 SHALL, while rst_n low, clear all valid bits, counters, jump flags and statistics counters regardless of clk.
REQ-026 SHALL drive o_hit=0, o_pred_taken=0, o_target=0 during reset; an update coincident with reset release is discarded.

Configuration
REQ-027 SHALL gate statistics with macro BTB_STATS_EN: defined -> o_lookup_count increments per cycle with i_lookup_valid, o_hit_count per o_hit, both wrap at 2^32; undefined -> both tied to 0, no counter flops.

Structure
REQ-028 SHALL place typedef BtbEntry (valid, tag, target, counter, is_jump) and BTB_DEFAULT_ENTRIES in mips_core_pkg; BranchOutcome is reused from it.
REQ-029 SHALL implement counter next-state in one sub-module btb_sat_cnt (2-bit saturating, outcome in, next value out).

Verification
REQ-030 SHALL cover: reset, lookup pc=0x0040_0010 -> o_hit=0, o_pred_taken=0, o_target=0.
REQ-031 SHALL cover: update pc=0x0040_0010 TAKEN target=0x0040_0100, next-cycle lookup -> o_hit=1, o_pred_taken=1, o_target=0x0040_0100.
REQ-032 SHALL cover: two further NOT_TAKEN updates on same pc -> counter 2->1->0, lookup o_hit=1, o_pred_taken=0; a NOT_TAKEN miss on pc=0x0040_0020 -> still o_hit=0.
REQ-033 SHALL cover: alias pc=0x0040_0110 (same index, ENTRIES=64) TAKEN target=0x0040_0200 -> 0x0040_0010 now misses, 0x0040_0110 hits.
REQ-034 SHALL cover: same-cycle lookup and update on one index -> old data that cycle, new data next; jump update -> o_pred_taken=1 after any number of NOT_TAKEN updates.
REQ-035 SHALL cover: with BTB_STATS_EN, 10 lookups incl. 4 hits -> counts 10/4; rst_n asserted mid-run -> counts and table cleared immediately.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome, BTB entry layout, address width.
// Used by the BTB top, its interface and the saturating-counter helper.
package mips_core_pkg;

  localparam int ADDR_WIDTH          = 32;
  localparam int BTB_DEFAULT_ENTRIES = 64;
  // Widest tag, i.e. the smallest legal table (16 entries).
  localparam int BTB_TAG_W           = ADDR_WIDTH - 6;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic                  valid;
    logic [BTB_TAG_W-1:0]  tag;
    logic [ADDR_WIDTH-1:0] target;
    logic [1:0]            counter;
    logic                  is_jump;
  } BtbEntry;

endpackage

// File: rtl/branch_target_buffer_if.sv
// BTB bus: fetch lookup, EX update feedback, statistics outputs.
// master = fetch/EX side driving requests; slave = the BTB.
interface branch_target_buffer_if;
  import mips_core_pkg::*;

  logic                  i_lookup_valid;
  logic [ADDR_WIDTH-1:0] i_lookup_pc;
  logic                  o_hit;
  logic                  o_pred_taken;
  logic [ADDR_WIDTH-1:0] o_target;
  logic                  i_upd_valid;
  logic [ADDR_WIDTH-1:0] i_upd_pc;
  logic [ADDR_WIDTH-1:0] i_upd_target;
  BranchOutcome          i_upd_outcome;
  logic                  i_upd_is_jump;
  logic [31:0]           o_lookup_count;
  logic [31:0]           o_hit_count;

  modport master (
    output i_lookup_valid, i_lookup_pc,
    output i_upd_valid, i_upd_pc, i_upd_target,
    output i_upd_outcome, i_upd_is_jump,
    input  o_hit, o_pred_taken, o_target,
    input  o_lookup_count, o_hit_count
  );

  modport slave (
    input  i_lookup_valid, i_lookup_pc,
    input  i_upd_valid, i_upd_pc, i_upd_target,
    input  i_upd_outcome, i_upd_is_jump,
    output o_hit, o_pred_taken, o_target,
    output o_lookup_count, o_hit_count
  );

endinterface

// File: rtl/btb_sat_cnt.sv
// 2-bit saturating counter next-state.
// Ports: i_cnt current value, i_outcome branch result, o_cnt next value.
module btb_sat_cnt
  import mips_core_pkg::*;
(
  input  logic [1:0]   i_cnt,
  input  BranchOutcome i_outcome,
  output logic [1:0]   o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    unique case (1'b1)
      (i_outcome == TAKEN) && (i_cnt != 2'd3):
        o_cnt = i_cnt + 2'd1;
      (i_outcome == NOT_TAKEN) && (i_cnt != 2'd0):
        o_cnt = i_cnt - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency lookup, EX-driven update, 2-bit counters.
// Ports: clk, rst_n (async low), bus (slave). Stats flops under BTB_STATS_EN.
module branch_target_buffer
  import mips_core_pkg::*;
#(
  parameter int ENTRIES = BTB_DEFAULT_ENTRIES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_target_buffer_if.slave  bus
);

  localparam int IDX = $clog2(ENTRIES);

  BtbEntry              r_tbl [ENTRIES];
  logic                 r_rst_q;

  logic [IDX-1:0]       w_lidx;
  logic [BTB_TAG_W-1:0] w_ltag;
  BtbEntry              w_lent;
  logic                 w_hit;

  logic [IDX-1:0]       w_uidx;
  logic [BTB_TAG_W-1:0] w_utag;
  BtbEntry              w_uent;
  logic                 w_uhit;
  logic                 w_taken;
  logic [1:0]           w_cnt_nxt;
  BtbEntry              w_new;
  logic                 w_wr;
  logic                 w_unused;

  assign w_lidx = bus.i_lookup_pc[IDX+1:2];
  assign w_ltag = BTB_TAG_W'(bus.i_lookup_pc[ADDR_WIDTH-1:IDX+2]);
  assign w_lent = r_tbl[w_lidx];
  assign w_hit  = bus.i_lookup_valid & w_lent.valid
                & (w_lent.tag == w_ltag);

  assign bus.o_hit        = w_hit;
  assign bus.o_pred_taken = w_hit & (w_lent.is_jump | w_lent.counter[1]);
  assign bus.o_target     = w_hit ? w_lent.target : '0;

  assign w_uidx  = bus.i_upd_pc[IDX+1:2];
  assign w_utag  = BTB_TAG_W'(bus.i_upd_pc[ADDR_WIDTH-1:IDX+2]);
  assign w_uent  = r_tbl[w_uidx];
  assign w_uhit  = w_uent.valid & (w_uent.tag == w_utag);
  assign w_taken = (bus.i_upd_outcome == TAKEN);

  assign w_unused = ^{bus.i_lookup_pc[1:0], bus.i_upd_pc[1:0]};

  btb_sat_cnt u_cnt (
    .i_cnt     (w_uent.counter),
    .i_outcome (bus.i_upd_outcome),
    .o_cnt     (w_cnt_nxt)
  );

  // r_rst_q drops updates in the first cycle after reset release.
  always_comb begin
    w_new = w_uent;
    w_wr  = 1'b0;
    if (bus.i_upd_valid && r_rst_q) begin
      if (w_uhit) begin
        w_wr          = 1'b1;
        w_new.counter = w_cnt_nxt;
        if (w_taken) w_new.target = bus.i_upd_target;
      end else if (w_taken) begin
        // Miss on TAKEN allocates, evicting any aliasing tag.
        w_wr  = 1'b1;
        w_new = '{valid:   1'b1,
                  tag:     w_utag,
                  target:  bus.i_upd_target,
                  counter: 2'd2,
                  is_jump: bus.i_upd_is_jump};
      end
      if (w_wr && bus.i_upd_is_jump) begin
        w_new.counter = 2'd3;
        w_new.is_jump = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= '0;
    end else begin
      r_rst_q <= 1'b1;
      if (w_wr) r_tbl[w_uidx] <= w_new;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_lk_cnt;
  logic [31:0] r_hit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_cnt  <= '0;
      r_hit_cnt <= '0;
    end else begin
      if (bus.i_lookup_valid) r_lk_cnt <= r_lk_cnt + 32'd1;
      if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
    end
  end

  assign bus.o_lookup_count = r_lk_cnt;
  assign bus.o_hit_count    = r_hit_cnt;
`else
  assign bus.o_lookup_count = '0;
  assign bus.o_hit_count    = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios plus random traffic
// compared against an array-based model of the table.
module tb_branch_target_buffer;
  import mips_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_target_buffer_if bus();

  branch_target_buffer #(.ENTRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  bit          m_valid  [64];
  logic [31:0] m_tag    [64];
  logic [31:0] m_target [64];
  int          m_cnt    [64];
  bit          m_jump   [64];
  bit          m_live;
  logic [31:0] m_lk;
  logic [31:0] m_ht;

  logic        o_h, o_p;
  logic [31:0] o_t;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic [31:0] tg(input logic [31:0] pc);
    return pc >> 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 0;
      m_jump[i]  = 0;
    end
    m_lk = 0;
    m_ht = 0;
  endtask

  task automatic model_upd(input logic [31:0] pc, input logic [31:0] t,
                           input bit tk, input bit jp);
    int  i;
    bit  h;
    i = idx(pc);
    h = m_valid[i] && (m_tag[i] == tg(pc));
    if (!h && !tk) return;
    if (!h) begin
      m_valid[i]  = 1;
      m_tag[i]    = tg(pc);
      m_target[i] = t;
      m_cnt[i]    = 2;
      m_jump[i]   = jp;
    end else begin
      if (tk) begin
        m_cnt[i]    = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_target[i] = t;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end
    if (jp) begin
      m_cnt[i]  = 3;
      m_jump[i] = 1;
    end
  endtask

  task automatic chk_counts(input string nm);
`ifdef BTB_STATS_EN
    chk({nm, "_lkcnt"}, bus.o_lookup_count, m_lk);
    chk({nm, "_hitcnt"}, bus.o_hit_count, m_ht);
`else
    chk({nm, "_lkcnt"}, bus.o_lookup_count, 32'd0);
    chk({nm, "_hitcnt"}, bus.o_hit_count, 32'd0);
`endif
  endtask

  // One clock: drive at negedge, check combinational outputs at +1,
  // then advance the model across the posedge.
  task automatic cycle(input bit lv, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc,
                       input logic [31:0] ut, input bit tk,
                       input bit jp, input string nm);
    int          li;
    bit          eh, ep;
    logic [31:0] et;
    bus.i_lookup_valid = lv;
    bus.i_lookup_pc    = lpc;
    bus.i_upd_valid    = uv;
    bus.i_upd_pc       = upc;
    bus.i_upd_target   = ut;
    bus.i_upd_outcome  = tk ? TAKEN : NOT_TAKEN;
    bus.i_upd_is_jump  = jp;
    #1;
    li = idx(lpc);
    eh = lv && m_valid[li] && (m_tag[li] == tg(lpc));
    ep = eh && (m_jump[li] || m_cnt[li] >= 2);
    et = eh ? m_target[li] : 32'd0;
    o_h = bus.o_hit;
    o_p = bus.o_pred_taken;
    o_t = bus.o_target;
    chk({nm, "_hit"}, {31'd0, o_h}, {31'd0, eh});
    chk({nm, "_pred"}, {31'd0, o_p}, {31'd0, ep});
    chk({nm, "_tgt"}, o_t, et);
    chk_counts(nm);
    @(posedge clk);
    if (lv) m_lk = m_lk + 1;
    if (eh) m_ht = m_ht + 1;
    if (uv && m_live) model_upd(upc, ut, tk, jp);
    m_live = 1;
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc, input string nm);
    cycle(1, pc, 0, 32'd0, 32'd0, 0, 0, nm);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] t,
                     input bit tk, input bit jp, input string nm);
    cycle(0, 32'd0, 1, pc, t, tk, jp, nm);
  endtask

  initial begin
    logic [31:0] lpc, upc, ut;
    model_clear();
    m_live = 0;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pc    = 32'h0040_0010;
    bus.i_upd_valid    = 1'b0;
    bus.i_upd_pc       = '0;
    bus.i_upd_target   = '0;
    bus.i_upd_outcome  = NOT_TAKEN;
    bus.i_upd_is_jump  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hit", {31'd0, bus.o_hit}, 32'd0);
    chk("rst_pred", {31'd0, bus.o_pred_taken}, 32'd0);
    chk("rst_tgt", bus.o_target, 32'd0);
    chk_counts("rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_live = 0;

    look(32'h0040_0010, "cold");
    chk("cold_hit_c", {31'd0, o_h}, 32'd0);
    chk("cold_tgt_c", o_t, 32'd0);

    upd(32'h0040_0010, 32'h0040_0100, 1, 0, "alloc");
    look(32'h0040_0010, "alloc_lk");
    chk("alloc_hit_c", {31'd0, o_h}, 32'd1);
    chk("alloc_pred_c", {31'd0, o_p}, 32'd1);
    chk("alloc_tgt_c", o_t, 32'h0040_0100);

    upd(32'h0040_0010, 32'h0, 0, 0, "nt1");
    upd(32'h0040_0010, 32'h0, 0, 0, "nt2");
    look(32'h0040_0010, "nt_lk");
    chk("nt_hit_c", {31'd0, o_h}, 32'd1);
    chk("nt_pred_c", {31'd0, o_p}, 32'd0);

    upd(32'h0040_0020, 32'h0040_0999, 0, 0, "ntmiss");
    look(32'h0040_0020, "ntmiss_lk");
    chk("ntmiss_hit_c", {31'd0, o_h}, 32'd0);

    upd(32'h0040_0110, 32'h0040_0200, 1, 0, "alias");
    look(32'h0040_0010, "alias_old");
    chk("alias_old_c", {31'd0, o_h}, 32'd0);
    look(32'h0040_0110, "alias_new");
    chk("alias_new_c", {31'd0, o_h}, 32'd1);
    chk("alias_tgt_c", o_t, 32'h0040_0200);

    cycle(1, 32'h0040_0110, 1, 32'h0040_0110, 32'h0040_0300, 1, 0, "same");
    chk("same_old_c", o_t, 32'h0040_0200);
    look(32'h0040_0110, "same_nxt");
    chk("same_new_c", o_t, 32'h0040_0300);

    upd(32'h0040_0400, 32'h0040_1000, 1, 1, "jmp");
    for (int i = 0; i < 5; i++) upd(32'h0040_0400, 32'h0, 0, 0, "jmp_nt");
    look(32'h0040_0400, "jmp_lk");
    chk("jmp_hit_c", {31'd0, o_h}, 32'd1);
    chk("jmp_pred_c", {31'd0, o_p}, 32'd1);

    rst_n = 1'b0;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pc    = 32'h0040_0400;
    bus.i_upd_valid    = 1'b0;
    #1;
    model_clear();
    chk("mid_rst_hit", {31'd0, bus.o_hit}, 32'd0);
    chk("mid_rst_pred", {31'd0, bus.o_pred_taken}, 32'd0);
    chk_counts("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_live = 0;
    upd(32'h0040_0400, 32'h0040_1000, 1, 0, "rel_upd");
    cycle(1, 32'h0040_0400, 1, 32'h0040_0400, 32'h0040_1000, 1, 0,
          "rel_chk");
    chk("rel_drop_c", {31'd0, o_h}, 32'd0);
    for (int i = 0; i < 9; i++)
      look((i % 2 == 0 && i < 8) ? 32'h0040_0400 : 32'h0040_0800, "st");
    upd(32'h0, 32'h0, 0, 0, "st_end");
`ifdef BTB_STATS_EN
    chk("stats_lk_c", bus.o_lookup_count, 32'd10);
    chk("stats_hit_c", bus.o_hit_count, 32'd4);
`else
    chk("stats_lk_c", bus.o_lookup_count, 32'd0);
    chk("stats_hit_c", bus.o_hit_count, 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      lpc = ((32'h4000 + $urandom_range(0, 2)) << 8)
          | (32'($urandom_range(0, 7)) << 2);
      upc = ((32'h4000 + $urandom_range(0, 2)) << 8)
          | (32'($urandom_range(0, 7)) << 2);
      ut  = $urandom & 32'hFFFF_FFFC;
      cycle(($urandom_range(0, 3) != 0), lpc,
            ($urandom_range(0, 1) == 1), upc, ut,
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
